modexp_engine: RTL and testbench

Parametrised modular-exponentiation controller, the successor of the fixed 512-bit exponentiation block. It computes x^e mod m with left-to-right square-and-multiply in the Montgomery domain, or a single Montgomery product in multiply mode. The block drives an external Montgomery multiplier through a start/done port, so one multiplier can be shared and the bench can substitute a behavioural model. It adds WIDTH/EXP_WIDTH parameters, a runtime exponent length, leading-zero skipping, a busy/done handshake and a multiplication counter.

---
 rtl/modexp_engine_if.sv | 36 +++
 rtl/modexp_engine.sv | 157 +++++++++++++++
 tb/tb_modexp_engine.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/modexp_engine_if.sv
// Request/response and multiplier-port bundle for modexp_engine.
// The engine takes the slave view; the requester, which also hosts the multiplier, takes the master view.
interface modexp_engine_if #(
    parameter int WIDTH     = 512,
    parameter int EXP_WIDTH = 512,
    parameter int CNT_W     = $clog2(EXP_WIDTH + 1)
) ();
    logic                 start;
    logic                 mode;
    logic [WIDTH-1:0]     modulus;
    logic [WIDTH-1:0]     rmodm;
    logic [WIDTH-1:0]     rsq;
    logic [WIDTH-1:0]     x;
    logic [EXP_WIDTH-1:0] exponent;
    logic [CNT_W-1:0]     exp_len;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     result;
    logic [15:0]          mm_count;
    logic                 mm_start;
    logic [WIDTH-1:0]     mm_a;
    logic [WIDTH-1:0]     mm_b;
    logic [WIDTH-1:0]     mm_m;
    logic [WIDTH-1:0]     mm_result;
    logic                 mm_done;

    modport slave (
        input  start, mode, modulus, rmodm, rsq, x, exponent, exp_len, mm_result, mm_done,
        output busy, done, result, mm_count, mm_start, mm_a, mm_b, mm_m
    );

    modport master (
        output start, mode, modulus, rmodm, rsq, x, exponent, exp_len, mm_result, mm_done,
        input  busy, done, result, mm_count, mm_start, mm_a, mm_b, mm_m
    );
endinterface

// File: rtl/modexp_engine.sv
// Left-to-right square-and-multiply controller in the Montgomery domain.
// All products go through an external multiplier via mm_start/mm_done.
module modexp_engine #(
    parameter int WIDTH     = 512,
    parameter int EXP_WIDTH = 512,
    parameter int CNT_W     = $clog2(EXP_WIDTH + 1)
) (
    input  logic           clk,
    input  logic           resetn,
    modexp_engine_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CONV_X, S_SCAN, S_SQUARE, S_MULT, S_CONV_OUT, S_MUL_ONLY, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] EXP_W_C = CNT_W'(EXP_WIDTH);

    state_t               state;
    logic                 busy_q;
    logic                 done_q;
    logic                 mm_start_q;
    logic [15:0]          mm_count_q;
    logic [WIDTH-1:0]     result_q;
    logic [WIDTH-1:0]     mm_a_q;
    logic [WIDTH-1:0]     mm_b_q;
    logic [WIDTH-1:0]     mod_q;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     xd_q;
    logic [EXP_WIDTH-1:0] exp_q;
    logic [CNT_W-1:0]     rem_q;
    logic                 seen_one_q;

    logic [CNT_W-1:0]     len_clamped;
    logic [CNT_W-1:0]     bit_idx;
    logic                 cur_bit;
    logic                 mm_wait;
    logic                 mm_fire;

    assign len_clamped = (bus.exp_len > EXP_W_C) ? EXP_W_C : bus.exp_len;
    assign bit_idx     = rem_q - CNT_W'(1);
    assign cur_bit     = |(exp_q & (EXP_WIDTH'(1) << bit_idx));

    // A completion only counts once the start pulse has gone out and we are actually waiting.
    assign mm_wait = (state == S_CONV_X || state == S_SQUARE || state == S_MULT ||
                      state == S_CONV_OUT || state == S_MUL_ONLY) && !mm_start_q;
    assign mm_fire = mm_wait && bus.mm_done;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mm_start_q <= 1'b0;
            mm_count_q <= '0;
            result_q   <= '0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            mod_q      <= '0;
            acc_q      <= '0;
            xd_q       <= '0;
            exp_q      <= '0;
            rem_q      <= '0;
            seen_one_q <= 1'b0;
        end else begin
            mm_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mod_q      <= bus.modulus;
                        exp_q      <= bus.exponent;
                        rem_q      <= len_clamped;
                        acc_q      <= bus.rmodm;
                        seen_one_q <= 1'b0;
                        busy_q     <= 1'b1;
                        // Both modes open with MM(x, rsq), so the first product is issued right here.
                        mm_a_q     <= bus.x;
                        mm_b_q     <= bus.rsq;
                        mm_start_q <= 1'b1;
                        mm_count_q <= 16'd1;
                        state      <= bus.mode ? S_MUL_ONLY : S_CONV_X;
                    end
                end
                S_CONV_X: begin
                    if (mm_fire) begin
                        xd_q  <= bus.mm_result;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (rem_q == '0) begin
                        mm_a_q     <= acc_q;
                        mm_b_q     <= WIDTH'(1);
                        mm_start_q <= 1'b1;
                        mm_count_q <= mm_count_q + 16'd1;
                        state      <= S_CONV_OUT;
                    end else if (!seen_one_q) begin
                        if (cur_bit) begin
                            acc_q      <= xd_q;
                            seen_one_q <= 1'b1;
                        end
                        rem_q <= rem_q - CNT_W'(1);
                    end else begin
                        mm_a_q     <= acc_q;
                        mm_b_q     <= acc_q;
                        mm_start_q <= 1'b1;
                        mm_count_q <= mm_count_q + 16'd1;
                        state      <= S_SQUARE;
                    end
                end
                S_SQUARE: begin
                    if (mm_fire) begin
                        acc_q <= bus.mm_result;
                        if (cur_bit) begin
                            mm_a_q     <= bus.mm_result;
                            mm_b_q     <= xd_q;
                            mm_start_q <= 1'b1;
                            mm_count_q <= mm_count_q + 16'd1;
                            state      <= S_MULT;
                        end else begin
                            rem_q <= rem_q - CNT_W'(1);
                            state <= S_SCAN;
                        end
                    end
                end
                S_MULT: begin
                    if (mm_fire) begin
                        acc_q <= bus.mm_result;
                        rem_q <= rem_q - CNT_W'(1);
                        state <= S_SCAN;
                    end
                end
                S_CONV_OUT, S_MUL_ONLY: begin
                    if (mm_fire) begin
                        result_q <= bus.mm_result;
                        done_q   <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.mm_count = mm_count_q;
    assign bus.mm_start = mm_start_q;
    assign bus.mm_a     = mm_a_q;
    assign bus.mm_b     = mm_b_q;
    assign bus.mm_m     = mod_q;
endmodule

// File: tb/tb_modexp_engine.sv
// Bench for modexp_engine: directed 8-bit jobs plus a randomised 16-bit run,
// both served by behavioural Montgomery multipliers and checked against plain modular arithmetic.
module tb_modexp_engine;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    modexp_engine_if #(.WIDTH(8),  .EXP_WIDTH(8))  b8 ();
    modexp_engine_if #(.WIDTH(16), .EXP_WIDTH(12)) b16 ();

    modexp_engine #(.WIDTH(8),  .EXP_WIDTH(8))  u8  (.clk(clk), .resetn(resetn), .bus(b8));
    modexp_engine #(.WIDTH(16), .EXP_WIDTH(12)) u16 (.clk(clk), .resetn(resetn), .bus(b16));

    int ncmp = 0;
    int nbad = 0;

    function automatic longint mm_ref(longint a, longint b, longint m, int w);
        longint t;
        if (m == 0) return 0;
        t = a * b;
        for (int i = 0; i < w; i++) begin
            if ((t & 1) != 0) t = t + m;
            t = t >> 1;
        end
        return t % m;
    endfunction

    function automatic longint powmod(longint xv, longint ev, longint m);
        longint r = 1 % m;
        for (longint i = 0; i < ev; i++) r = (r * xv) % m;
        return r;
    endfunction

    function automatic int exp_count(longint ee);
        int msb = -1;
        int p = 0;
        for (int i = 0; i < 16; i++)
            if (((ee >> i) & 1) != 0) begin msb = i; p++; end
        if (p == 0) return 2;
        return 2 + msb + (p - 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nbad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Behavioural multipliers: fixed latency 5 for the 8-bit engine, random 1..4 for the 16-bit one.
    int cnt8 = 0;
    longint ca8, cb8, cm8;
    always @(posedge clk) begin
        b8.mm_done <= 1'b0;
        if (cnt8 == 1) begin
            b8.mm_done   <= 1'b1;
            b8.mm_result <= 8'(mm_ref(ca8, cb8, cm8, 8));
        end
        if (cnt8 != 0) cnt8 <= cnt8 - 1;
        if (b8.mm_start === 1'b1) begin
            cnt8 <= 5;
            ca8  <= longint'(b8.mm_a);
            cb8  <= longint'(b8.mm_b);
            cm8  <= longint'(b8.mm_m);
        end
    end

    int cnt16 = 0;
    int viol16 = 0;
    logic [15:0] ca16, cb16, cm16;
    always @(posedge clk) begin
        b16.mm_done <= 1'b0;
        if (cnt16 != 0 && (b16.mm_a !== ca16 || b16.mm_b !== cb16)) viol16 <= viol16 + 1;
        if (cnt16 == 1) begin
            b16.mm_done   <= 1'b1;
            b16.mm_result <= 16'(mm_ref(longint'(ca16), longint'(cb16), longint'(cm16), 16));
        end
        if (cnt16 != 0) cnt16 <= cnt16 - 1;
        if (b16.mm_start === 1'b1) begin
            cnt16 <= int'($urandom_range(1, 4));
            ca16  <= b16.mm_a;
            cb16  <= b16.mm_b;
            cm16  <= b16.mm_m;
        end
    end

    int dn8 = 0;
    always @(posedge clk) if (b8.done === 1'b1) dn8 <= dn8 + 1;

    task automatic run8(input logic [7:0] xi, input logic [7:0] ei, input logic [3:0] li,
                        input logic mi, input bit poke, output int cyc);
        int guard = 0;
        while (b8.busy === 1'b1 && guard < 100) begin @(negedge clk); guard++; end
        @(negedge clk);
        b8.x = xi; b8.exponent = ei; b8.exp_len = li; b8.mode = mi; b8.start = 1'b1;
        @(posedge clk); #1;
        b8.start = 1'b0;
        cyc = 0;
        while (b8.done !== 1'b1 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (poke && cyc == 3) begin
                b8.start = 1'b1; b8.mode = 1'b1; b8.x = 8'd77;
            end else begin
                b8.start = 1'b0;
            end
        end
        if (b8.done !== 1'b1) check("done8_wait", {63'd0, b8.done}, 64'd1);
    endtask

    task automatic run16(input logic [15:0] mi, input logic [15:0] xi, input logic [11:0] ei,
                         input logic [3:0] li);
        int guard = 0;
        int cyc = 0;
        while (b16.busy === 1'b1 && guard < 100) begin @(negedge clk); guard++; end
        @(negedge clk);
        b16.modulus  = mi;
        b16.rmodm    = 16'(65536 % longint'(mi));
        b16.rsq      = 16'(((65536 % longint'(mi)) * (65536 % longint'(mi))) % longint'(mi));
        b16.x = xi; b16.exponent = ei; b16.exp_len = li; b16.mode = 1'b0; b16.start = 1'b1;
        @(posedge clk); #1;
        b16.start = 1'b0;
        while (b16.done !== 1'b1 && cyc < 2000) begin @(posedge clk); #1; cyc++; end
        if (b16.done !== 1'b1) check("done16_wait", {63'd0, b16.done}, 64'd1);
    endtask

    initial begin
        int cyc, d0, nst, guard, k, vb;
        longint mr, xr, er, ee;
        logic [3:0] lr;

        b8.start = 0; b8.mode = 0; b8.modulus = 8'd239; b8.rmodm = 8'd17; b8.rsq = 8'd50;
        b8.x = 0; b8.exponent = 0; b8.exp_len = 0;
        b16.start = 0; b16.mode = 0; b16.modulus = 16'd3; b16.rmodm = 0; b16.rsq = 0;
        b16.x = 0; b16.exponent = 0; b16.exp_len = 0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, b8.busy}, 64'd0);
        check("rst_done", {63'd0, b8.done}, 64'd0);
        check("rst_result", {56'd0, b8.result}, 64'd0);
        check("rst_mm_start", {63'd0, b8.mm_start}, 64'd0);
        check("rst_mm_count", {48'd0, b8.mm_count}, 64'd0);
        @(negedge clk); resetn = 1'b1;

        // 5^3 with a stray start while busy
        d0 = dn8;
        run8(8'd5, 8'd3, 4'd2, 1'b0, 1'b1, cyc);
        check("e3_result", {56'd0, b8.result}, 64'd125);
        check("e3_count", {48'd0, b8.mm_count}, 64'd4);
        repeat (3) @(posedge clk);
        #1;
        check("e3_one_done", 64'(dn8 - d0), 64'd1);

        run8(8'd5, 8'h80, 4'd8, 1'b0, 1'b0, cyc);
        check("e80_result", {56'd0, b8.result}, 64'(powmod(5, 128, 239)));
        check("e80_count", {48'd0, b8.mm_count}, 64'd9);

        run8(8'd5, 8'h00, 4'd8, 1'b0, 1'b0, cyc);
        check("e0_result", {56'd0, b8.result}, 64'd1);
        check("e0_count", {48'd0, b8.mm_count}, 64'd2);

        run8(8'd5, 8'hFF, 4'd0, 1'b0, 1'b0, cyc);
        check("len0_result", {56'd0, b8.result}, 64'd1);
        check("len0_count", {48'd0, b8.mm_count}, 64'd2);

        run8(8'd17, 8'h00, 4'd0, 1'b1, 1'b0, cyc);
        check("mode1_result", {56'd0, b8.result}, 64'(mm_ref(17, 50, 239, 8)));
        check("mode1_count", {48'd0, b8.mm_count}, 64'd1);
        check("mode1_latency", 64'(cyc), 64'd7);

        // Clamp: exp_len 15 on an 8-bit exponent behaves like 8
        run8(8'd3, 8'hA5, 4'd15, 1'b0, 1'b0, cyc);
        check("clamp_result", {56'd0, b8.result}, 64'(powmod(3, 165, 239)));
        check("clamp_count", {48'd0, b8.mm_count}, 64'(exp_count(165)));

        // Abort in the first SQUARE; the pending multiplier completion must be ignored
        guard = 0;
        while (b8.busy === 1'b1 && guard < 100) begin @(negedge clk); guard++; end
        @(negedge clk);
        b8.x = 8'd5; b8.exponent = 8'h80; b8.exp_len = 4'd8; b8.mode = 1'b0; b8.start = 1'b1;
        @(posedge clk); #1;
        b8.start = 1'b0;
        nst = 0; guard = 0;
        while (guard < 500) begin
            if (b8.mm_start === 1'b1) nst++;
            if (nst == 2) break;
            @(posedge clk); #1;
            guard++;
        end
        check("square_reached", 64'(nst), 64'd2);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", {63'd0, b8.busy}, 64'd0);
        check("abort_done", {63'd0, b8.done}, 64'd0);
        check("abort_result", {56'd0, b8.result}, 64'd0);
        check("abort_count", {48'd0, b8.mm_count}, 64'd0);
        resetn = 1'b1;
        guard = 0;
        while (b8.mm_done !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
        check("late_mm_done", {63'd0, b8.mm_done}, 64'd1);
        @(posedge clk); #1;
        check("late_busy", {63'd0, b8.busy}, 64'd0);
        check("late_result", {56'd0, b8.result}, 64'd0);
        check("late_mm_start", {63'd0, b8.mm_start}, 64'd0);

        run8(8'd5, 8'h80, 4'd8, 1'b0, 1'b0, cyc);
        check("post_rst_result", {56'd0, b8.result}, 64'(powmod(5, 128, 239)));
        check("post_rst_count", {48'd0, b8.mm_count}, 64'd9);

        // Randomised 16-bit jobs against plain modular exponentiation
        for (int j = 0; j < 500; j++) begin
            mr = longint'($urandom_range(1, 32767)) * 2 + 1;
            xr = longint'($urandom) % mr;
            er = longint'($urandom & 32'hFFF);
            lr = 4'($urandom_range(0, 15));
            k  = (int'(lr) > 12) ? 12 : int'(lr);
            ee = er & ((longint'(1) << k) - 1);
            vb = viol16;
            run16(16'(mr), 16'(xr), 12'(er), lr);
            check("rnd_result", {48'd0, b16.result}, 64'(powmod(xr, ee, mr)));
            check("rnd_count", {48'd0, b16.mm_count}, 64'(exp_count(ee)));
            check("rnd_operand_stable", 64'(viol16 - vb), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
